// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock mode sequencer: state encoding,
// keypad constants and the default entry timeout.
package alarm_pkg;

  // Seconds without a key press before an entry is abandoned.
  localparam int unsigned TIMEOUT_S_DEFAULT = 10;

  // Keypad code reported when nothing is pressed. Codes above it are also
  // treated as "no key".
  localparam logic [3:0] NOKEY = 4'hA;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    SHOW_ALARM       = 3'd1,
    KEY_STORED       = 3'd2,
    KEY_WAITED       = 3'd3,
    KEY_ENTRY        = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_e;

  // Keypad codes 0-9 are digits; every code from NOKEY upward is not.
  function automatic logic is_digit(input logic [3:0] key);
    return (key < NOKEY);
  endfunction

endpackage

// File: rtl/alarm_timeout_counter.sv
// Counts one-second ticks while the keypad entry is idle. Clearing wins
// over counting, and the count sticks at the limit until cleared.
module alarm_timeout_counter
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = TIMEOUT_S_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(TIMEOUT_S + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic tick_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_S);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, advance on a tick, or hold once saturated.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout_o = (count_q == LIMIT);

endmodule

// File: rtl/alarm_controller_fsm.sv
// Mode sequencer for the alarm clock. It takes keypad codes, the alarm and
// time buttons and the 1 Hz tick. It drives the LCD source selects, the
// key-register shift and the alarm/current-time load strobes. All outputs
// are decoded from the registered state alone.
module alarm_controller_fsm
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = TIMEOUT_S_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(TIMEOUT_S + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second_i,
  input  logic [3:0] key_i,
  input  logic       alarm_button_i,
  input  logic       time_button_i,
  output logic       shift_o,
  output logic       show_a_o,
  output logic       show_new_time_o,
  output logic       load_new_a_o,
  output logic       load_new_c_o
);

  state_e state_q;
  state_e state_d;
  logic   digit;
  logic   timeout_clear;
  logic   timeout_hit;

  assign digit = is_digit(key_i);

  // The timeout only runs while waiting on the user. Passing through
  // KEY_STORED clears it, so every accepted digit restarts the timeout.
  assign timeout_clear = !((state_q == KEY_WAITED) || (state_q == KEY_ENTRY));

  alarm_timeout_counter #(
    .TIMEOUT_S (TIMEOUT_S),
    .CNT_W     (CNT_W)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (timeout_clear),
    .tick_i    (one_second_i),
    .timeout_o (timeout_hit)
  );

  // State register. Reset drops any entry in progress without a load.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SHOW_TIME;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and Moore output decode. Inside each state the
  // events are tested in priority order: alarm, time, digit, timeout.
  always_comb begin
    state_d         = state_q;
    shift_o         = 1'b0;
    show_a_o        = 1'b0;
    show_new_time_o = 1'b0;
    load_new_a_o    = 1'b0;
    load_new_c_o    = 1'b0;
    case (state_q)
      SHOW_TIME: begin
        if (alarm_button_i) begin
          state_d = SHOW_ALARM;
        end else if (digit) begin
          state_d = KEY_STORED;
        end
      end
      SHOW_ALARM: begin
        show_a_o = 1'b1;
        if (!alarm_button_i) begin
          state_d = SHOW_TIME;
        end
      end
      KEY_STORED: begin
        shift_o         = 1'b1;
        show_new_time_o = 1'b1;
        state_d         = KEY_WAITED;
      end
      KEY_WAITED: begin
        show_new_time_o = 1'b1;
        if (!digit) begin
          state_d = KEY_ENTRY;
        end else if (timeout_hit) begin
          state_d = SHOW_TIME;
        end
      end
      KEY_ENTRY: begin
        show_new_time_o = 1'b1;
        if (alarm_button_i) begin
          state_d = SET_ALARM_TIME;
        end else if (time_button_i) begin
          state_d = SET_CURRENT_TIME;
        end else if (digit) begin
          state_d = KEY_STORED;
        end else if (timeout_hit) begin
          state_d = SHOW_TIME;
        end
      end
      SET_ALARM_TIME: begin
        load_new_a_o = 1'b1;
        state_d      = SHOW_TIME;
      end
      SET_CURRENT_TIME: begin
        load_new_c_o = 1'b1;
        state_d      = SHOW_TIME;
      end
      default: begin
        state_d = SHOW_TIME;
      end
    endcase
  end

endmodule

// File: tb/tb_alarm_controller_fsm.sv
// Self-checking bench for alarm_controller_fsm. A behavioural model
// describes what the user sees: an alarm view, an entry session with a
// pending key release, an idle-seconds count and a one-shot commit.
// Directed scenarios are followed by a randomized soak.
module tb_alarm_controller_fsm;

  localparam int TIMEOUT = 10;
  localparam logic [3:0] NOKEY_CODE = 4'hA;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = NOKEY_CODE;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       shift, show_a, show_new_time, load_new_a, load_new_c;
  logic [4:0] obsOut;

  int checkCount = 0;
  int passCount  = 0;

  // Model of the user-visible behaviour.
  bit mAlarmView, mEntry, mJustPressed, mWaitRelease;
  int mCommit;   // 0 none, 1 alarm commit, 2 current-time commit
  int mSeconds;  // idle seconds counted during the entry session

  assign obsOut = {shift, show_a, show_new_time, load_new_a, load_new_c};

  alarm_controller_fsm dut (
    .clock           (clock),
    .reset           (reset),
    .one_second_i    (one_second),
    .key_i           (key),
    .alarm_button_i  (alarm_button),
    .time_button_i   (time_button),
    .shift_o         (shift),
    .show_a_o        (show_a),
    .show_new_time_o (show_new_time),
    .load_new_a_o    (load_new_a),
    .load_new_c_o    (load_new_c)
  );

  always #5 clock = ~clock;

  function automatic logic [4:0] expOut();
    return {mJustPressed, mAlarmView, mEntry, (mCommit == 1), (mCommit == 2)};
  endfunction

  // Advance the model by one clock using the inputs sampled at that edge.
  task automatic modelStep(input bit r, input logic [3:0] k, input bit a,
                           input bit t, input bit s);
    bit isDigit   = (k <= 4'd9);
    bit timedOut  = (mSeconds >= TIMEOUT);
    int nextSec   = 0;
    if (mEntry && !mJustPressed) begin
      nextSec = mSeconds + int'(s);
      if (nextSec > TIMEOUT) nextSec = TIMEOUT;
    end
    if (r) begin
      mAlarmView = 0; mEntry = 0; mJustPressed = 0; mWaitRelease = 0;
      mCommit = 0; mSeconds = 0;
      return;
    end
    if (mCommit != 0) begin
      mCommit = 0;
    end else if (mAlarmView) begin
      mAlarmView = a;
    end else if (mJustPressed) begin
      mJustPressed = 0;
      mWaitRelease = 1;
    end else if (mEntry && mWaitRelease) begin
      if (!isDigit) begin
        mWaitRelease = 0;
      end else if (timedOut) begin
        mEntry = 0;
        mWaitRelease = 0;
      end
    end else if (mEntry) begin
      if (a) begin
        mEntry = 0; mCommit = 1;
      end else if (t) begin
        mEntry = 0; mCommit = 2;
      end else if (isDigit) begin
        mJustPressed = 1;
      end else if (timedOut) begin
        mEntry = 0;
      end
    end else begin
      if (a) begin
        mAlarmView = 1;
      end else if (isDigit) begin
        mEntry = 1;
        mJustPressed = 1;
      end
    end
    mSeconds = nextSec;
  endtask

  // Drive one cycle of inputs, clock it, and leave time for outputs to settle.
  task automatic applyStimulus(input bit r, input logic [3:0] k, input bit a,
                               input bit t, input bit s);
    reset = r; key = k; alarm_button = a; time_button = t; one_second = s;
    @(posedge clock);
    modelStep(r, k, a, t, s);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, NOKEY_CODE, 0, 0, 0);
      checkCount++;
      if (obsOut !== 5'b0) $display("[TB] FAIL reset_hold cycle %0d: got %b expected 00000", i, obsOut);
      else passCount++;
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, NOKEY_CODE, 0, 0, 0);
      checkCount++;
      if (obsOut !== 5'b0) $display("[TB] FAIL idle cycle %0d: got %b expected 00000", i, obsOut);
      else passCount++;
    end
  endtask

  task automatic test_entry_alarm_commit();
    int nShift = 0, nLoadA = 0, nLoadC = 0;
    logic [3:0] d1 = 4'($urandom_range(0, 9));
    logic [3:0] d2 = 4'($urandom_range(0, 9));
    logic [3:0] seqKey [13];
    bit         seqAlarm [13];
    for (int i = 0; i < 13; i++) begin seqKey[i] = NOKEY_CODE; seqAlarm[i] = 0; end
    for (int i = 0; i < 5; i++) seqKey[i] = d1;
    for (int i = 7; i < 10; i++) seqKey[i] = d2;
    seqAlarm[11] = 1;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(0, seqKey[i], seqAlarm[i], 0, 0);
      nShift += int'(shift); nLoadA += int'(load_new_a); nLoadC += int'(load_new_c);
      checkCount++;
      if (obsOut !== expOut()) $display("[TB] FAIL entry_commit cycle %0d: got %b expected %b", i, obsOut, expOut());
      else passCount++;
    end
    checkCount++;
    if (nShift !== 2) $display("[TB] FAIL entry_shift_count: got %0d expected 2", nShift);
    else passCount++;
    checkCount++;
    if (nLoadA !== 1 || nLoadC !== 0) $display("[TB] FAIL entry_load_count: got a=%0d c=%0d expected a=1 c=0", nLoadA, nLoadC);
    else passCount++;
    checkCount++;
    if (obsOut !== 5'b0) $display("[TB] FAIL entry_return_idle: got %b expected 00000", obsOut);
    else passCount++;
  endtask

  task automatic test_alarm_view();
    int nShowA = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, NOKEY_CODE, (i < 6), 0, 0);
      nShowA += int'(show_a);
      checkCount++;
      if (obsOut !== expOut()) $display("[TB] FAIL alarm_view cycle %0d: got %b expected %b", i, obsOut, expOut());
      else passCount++;
    end
    checkCount++;
    if (nShowA !== 6) $display("[TB] FAIL alarm_view_length: got %0d expected 6", nShowA);
    else passCount++;
  endtask

  // Enter KEY_ENTRY with one digit pressed for two cycles and released.
  task automatic enterEntry();
    logic [3:0] d = 4'($urandom_range(0, 9));
    applyStimulus(0, d, 0, 0, 0);
    applyStimulus(0, d, 0, 0, 0);
    applyStimulus(0, NOKEY_CODE, 0, 0, 0);
  endtask

  task automatic test_timeout();
    enterEntry();
    for (int p = 1; p <= TIMEOUT; p++) begin
      applyStimulus(0, NOKEY_CODE, 0, 0, 1);
      checkCount++;
      if (show_new_time !== 1'b1) $display("[TB] FAIL timeout_pulse %0d: got %b expected 1", p, show_new_time);
      else passCount++;
      for (int g = 0; g < 3; g++) begin
        applyStimulus(0, NOKEY_CODE, 0, 0, 0);
        checkCount++;
        if (obsOut !== expOut()) $display("[TB] FAIL timeout_gap p%0d g%0d: got %b expected %b", p, g, obsOut, expOut());
        else passCount++;
        if (p == TIMEOUT && g == 0) begin
          checkCount++;
          if (obsOut !== 5'b0) $display("[TB] FAIL timeout_exit: got %b expected 00000", obsOut);
          else passCount++;
        end
      end
    end
    // Restart: a digit after the ninth pulse pushes the deadline out.
    enterEntry();
    for (int p = 1; p <= TIMEOUT; p++) begin
      if (p == TIMEOUT) enterEntry();
      applyStimulus(0, NOKEY_CODE, 0, 0, 1);
      for (int g = 0; g < 3; g++) applyStimulus(0, NOKEY_CODE, 0, 0, 0);
      checkCount++;
      if (obsOut !== expOut()) $display("[TB] FAIL restart_pulse %0d: got %b expected %b", p, obsOut, expOut());
      else passCount++;
    end
    checkCount++;
    if (show_new_time !== 1'b1) $display("[TB] FAIL restart_no_timeout: got %b expected 1", show_new_time);
    else passCount++;
    for (int i = 0; i < 4 * TIMEOUT; i++) applyStimulus(0, NOKEY_CODE, 0, 0, (i % 4 == 0));
    checkCount++;
    if (obsOut !== 5'b0) $display("[TB] FAIL restart_final_timeout: got %b expected 00000", obsOut);
    else passCount++;
  endtask

  task automatic test_simultaneous_buttons();
    int nLoadA = 0, nLoadC = 0;
    enterEntry();
    applyStimulus(0, 4'($urandom_range(0, 9)), 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      nLoadA += int'(load_new_a); nLoadC += int'(load_new_c);
      checkCount++;
      if (obsOut !== expOut()) $display("[TB] FAIL both_buttons cycle %0d: got %b expected %b", i, obsOut, expOut());
      else passCount++;
      applyStimulus(0, NOKEY_CODE, 0, 0, 0);
    end
    checkCount++;
    if (nLoadA !== 1 || nLoadC !== 0) $display("[TB] FAIL both_buttons_loads: got a=%0d c=%0d expected a=1 c=0", nLoadA, nLoadC);
    else passCount++;
  endtask

  task automatic test_time_commit_and_reset();
    int nLoadC = 0, nLoads = 0;
    logic [3:0] d = 4'($urandom_range(0, 9));
    enterEntry();
    applyStimulus(0, NOKEY_CODE, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      nLoadC += int'(load_new_c);
      checkCount++;
      if (obsOut !== expOut()) $display("[TB] FAIL time_commit cycle %0d: got %b expected %b", i, obsOut, expOut());
      else passCount++;
      applyStimulus(0, NOKEY_CODE, 0, 0, 0);
    end
    checkCount++;
    if (nLoadC !== 1) $display("[TB] FAIL time_commit_count: got %0d expected 1", nLoadC);
    else passCount++;
    applyStimulus(0, d, 0, 0, 0);
    applyStimulus(0, d, 0, 0, 0);
    applyStimulus(0, d, 0, 0, 0);
    checkCount++;
    if (obsOut !== 5'b00100) $display("[TB] FAIL key_waited_view: got %b expected 00100", obsOut);
    else passCount++;
    applyStimulus(1, NOKEY_CODE, 0, 0, 0);
    checkCount++;
    if (obsOut !== 5'b0) $display("[TB] FAIL reset_mid_entry: got %b expected 00000", obsOut);
    else passCount++;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, NOKEY_CODE, 0, 0, 0);
      nLoads += int'(load_new_a) + int'(load_new_c);
    end
    checkCount++;
    if (nLoads !== 0) $display("[TB] FAIL reset_no_load: got %0d expected 0", nLoads);
    else passCount++;
  endtask

  task automatic test_random_soak();
    logic [3:0] rk = NOKEY_CODE;
    bit ra = 0, rt = 0;
    logic [2:0] prevStrobe = 3'b0;
    logic [2:0] curStrobe;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0)
        rk = ($urandom_range(0, 1) == 0) ? NOKEY_CODE : 4'($urandom_range(0, 15));
      if (ra) ra = ($urandom_range(0, 2) != 0);
      else    ra = ($urandom_range(0, 11) == 0);
      rt = ($urandom_range(0, 9) == 0);
      applyStimulus(($urandom_range(0, 199) == 0), rk, ra, rt, ($urandom_range(0, 2) == 0));
      checkCount++;
      if (obsOut !== expOut()) $display("[TB] FAIL soak cycle %0d: got %b expected %b", i, obsOut, expOut());
      else passCount++;
      curStrobe = {shift, load_new_a, load_new_c};
      checkCount++;
      if (($countones(curStrobe) > 1) || ((curStrobe & prevStrobe) != 3'b0))
        $display("[TB] FAIL soak_strobes cycle %0d: got %b after %b expected one-shot", i, curStrobe, prevStrobe);
      else passCount++;
      prevStrobe = curStrobe;
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    mAlarmView = 0; mEntry = 0; mJustPressed = 0; mWaitRelease = 0;
    mCommit = 0; mSeconds = 0;
    test_reset();
    test_entry_alarm_commit();
    test_alarm_view();
    test_timeout();
    test_simultaneous_buttons();
    test_time_commit_and_reset();
    test_random_soak();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
